// File: rtl/sub_serial.sv
// Bit-serial subtractor: out = (a^A_MASK) - (b^B_MASK), LSB first, after DELAY wait cycles.
// Define SUB_SERIAL_SAT_EN to saturate the result to zero on underflow.
module sub_serial #(
  parameter int unsigned      WIDTH  = 8,
  parameter int unsigned      DELAY  = 3,
  parameter logic [WIDTH-1:0] A_MASK = '0,
  parameter logic [WIDTH-1:0] B_MASK = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned DW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [CW-1:0] CLAST = CW'(WIDTH - 1);
  localparam logic [DW-1:0] DLAST = DW'((DELAY > 0) ? DELAY - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SUB,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [CW-1:0]    count;
  logic [DW-1:0]    dcount;
  logic             borrow;

  logic a_bit;
  logic b_bit;
  logic diff_bit;
  logic next_borrow;

  always_comb begin
    a_bit       = a_reg[0];
    b_bit       = b_reg[0];
    diff_bit    = a_bit ^ b_bit ^ borrow;
    next_borrow = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      out    <= '0;
      count  <= '0;
      dcount <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en) begin
            a_reg  <= a ^ A_MASK;
            b_reg  <= b ^ B_MASK;
            out    <= '0;
            borrow <= 1'b0;
            count  <= '0;
            dcount <= '0;
            state  <= (DELAY > 0) ? S_WAIT : S_SUB;
          end
        end
        S_WAIT: begin
          dcount <= dcount + 1'b1;
          if (dcount == DLAST) state <= S_SUB;
        end
        S_SUB: begin
          borrow <= next_borrow;
          out    <= {diff_bit, out[WIDTH-1:1]};
          a_reg  <= a_reg >> 1;
          b_reg  <= b_reg >> 1;
          count  <= count + 1'b1;
          if (count == CLAST) begin
            state <= S_DONE;
`ifdef SUB_SERIAL_SAT_EN
            // Final borrow set means underflow: clamp instead of wrapping.
            if (next_borrow) out <= '0;
`endif
          end
        end
        S_DONE: begin
          if (en) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign borrow_out = (state == S_DONE) & borrow;
  assign busy       = (state == S_WAIT) | (state == S_SUB);
  assign done       = (state == S_DONE);

endmodule

// File: tb/tb_sub_serial.sv
// Directed self-checking bench for sub_serial: default instance plus a masked, zero-delay instance.
module tb_sub_serial;

  logic       clk;
  logic       rst_n;
  logic       en0, en1;
  logic [7:0] a0, b0, a1, b1;
  logic [7:0] out0, out1;
  logic       borrow0, borrow1;
  logic       busy0, busy1;
  logic       done0, done1;

  int vectors;
  int miscompares;
  int edges;
  int busy_n;

`ifdef SUB_SERIAL_SAT_EN
  localparam logic [7:0] EXP_10_20 = 8'h00;
  localparam logic [7:0] EXP_00_01 = 8'h00;
  localparam logic [7:0] EXP_00_FF = 8'h00;
`else
  localparam logic [7:0] EXP_10_20 = 8'hF0;
  localparam logic [7:0] EXP_00_01 = 8'hFF;
  localparam logic [7:0] EXP_00_FF = 8'h01;
`endif

  sub_serial dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en0),
    .a          (a0),
    .b          (b0),
    .out        (out0),
    .borrow_out (borrow0),
    .busy       (busy0),
    .done       (done0)
  );

  sub_serial #(
    .WIDTH  (8),
    .DELAY  (0),
    .A_MASK (8'h3E),
    .B_MASK (8'hA4)
  ) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en1),
    .a          (a1),
    .b          (b1),
    .out        (out1),
    .borrow_out (borrow1),
    .busy       (busy1),
    .done       (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done0();
    while (!done0 && edges < 100) begin
      step();
      edges++;
      if (busy0) busy_n++;
    end
  endtask

  task automatic wait_done1();
    while (!done1 && edges < 100) begin
      step();
      edges++;
    end
  endtask

  task automatic op0(input logic [7:0] av, input logic [7:0] bv);
    a0 = av; b0 = bv; en0 = 1'b1;
    step();
    en0 = 1'b0;
    edges = 1;
    busy_n = busy0 ? 1 : 0;
    wait_done0();
  endtask

  task automatic op1(input logic [7:0] av, input logic [7:0] bv);
    a1 = av; b1 = bv; en1 = 1'b1;
    step();
    en1 = 1'b0;
    edges = 1;
    wait_done1();
  endtask

  task automatic ack0();
    en0 = 1'b1;
    step();
    en0 = 1'b0;
    chk("ack0_idle", {done0, busy0}, 2'b00);
  endtask

  task automatic ack1();
    en1 = 1'b1;
    step();
    en1 = 1'b0;
    chk("ack1_idle", {done1, busy1}, 2'b00);
  endtask

  initial begin
    vectors = 0; miscompares = 0; edges = 0; busy_n = 0;
    rst_n = 1'b0; en0 = 1'b0; en1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    #12;
    chk("reset_out", out0, 8'h00);
    chk("reset_flags", {borrow0, busy0, done0}, 3'b000);
    rst_n = 1'b1;
    step();
    step();
    chk("idle_no_en", {out0, busy0, done0}, 10'h000);

    // 0x5A - 0x3C with default delay
    op0(8'h5A, 8'h3C);
    chk("t1_edges", edges, 12);
    chk("t1_busy_cycles", busy_n, 11);
    chk("t1_out", out0, 8'h1E);
    chk("t1_borrow", borrow0, 1'b0);
    step();
    chk("t1_done_sticky", {done0, out0}, {1'b1, 8'h1E});
    ack0();

    // underflow
    op0(8'h10, 8'h20);
    chk("t2_out", out0, EXP_10_20);
    chk("t2_borrow", borrow0, 1'b1);
    ack0();

    // masked operands, no delay
    op1(8'h64, 8'h98);
    chk("t3_edges", edges, 9);
    chk("t3_out", out1, 8'h1E);
    chk("t3_borrow", borrow1, 1'b0);
    ack1();
    op1(8'h3E, 8'hA5);
    chk("t3b_out", out1, EXP_00_01);
    chk("t3b_borrow", borrow1, 1'b1);
    ack1();

    // asynchronous reset during the 4th SUB cycle
    a0 = 8'h5A; b0 = 8'h3C; en0 = 1'b1;
    step();
    en0 = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("t4_partial", {busy0, out0}, {1'b1, 8'hC0});
    #2 rst_n = 1'b0;
    #1;
    chk("t4_async", {out0, busy0, done0}, 10'h000);
    #3 rst_n = 1'b1;
    step();
    chk("t4_idle", {busy0, done0}, 2'b00);
    op0(8'hFF, 8'h01);
    chk("t4_out", out0, 8'hFE);
    chk("t4_borrow", borrow0, 1'b0);
    ack0();

    // en held high throughout; operands change mid-SUB
    a0 = 8'h5A; b0 = 8'h3C; en0 = 1'b1;
    step();
    edges = 1;
    busy_n = 0;
    while (!done0 && edges < 100) begin
      if (edges == 6) begin
        a0 = 8'h00; b0 = 8'hFF;
      end
      step();
      edges++;
    end
    chk("t5_edges", edges, 12);
    chk("t5_out", out0, 8'h1E);
    step();
    chk("t5_idle", {done0, busy0}, 2'b00);
    step();
    chk("t5_reload", {done0, busy0}, 2'b01);
    en0 = 1'b0;
    edges = 0;
    wait_done0();
    chk("t5_new_out", out0, EXP_00_FF);
    chk("t5_new_borrow", borrow0, 1'b1);
    ack0();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
